// File: rtl/timer1_pkg.sv
// Timer1 shared definitions: bus addresses, T1CON bit positions and the
// prescaler ratio encoding.
package timer1_pkg;

  localparam logic [8:0] TMR1L_ADDR_DEFAULT = 9'h00E;
  localparam logic [8:0] TMR1H_ADDR_DEFAULT = 9'h00F;
  localparam logic [8:0] T1CON_ADDR_DEFAULT = 9'h010;

  // T1CON bit positions
  localparam int T1CON_TMR1ON  = 0;
  localparam int T1CON_TMR1CS  = 1;
  localparam int T1CON_T1SYNCN = 2;
  localparam int T1CON_T1OSCEN = 3;
  localparam int T1CON_CKPS_LO = 4;
  localparam int T1CON_CKPS_HI = 5;

  typedef enum logic [1:0] {
    CKPS_1 = 2'b00,
    CKPS_2 = 2'b01,
    CKPS_4 = 2'b10,
    CKPS_8 = 2'b11
  } ckps_e;

  // Last prescaler count before an increment (ratio - 1).
  function automatic logic [2:0] ckps_last(input ckps_e ckps);
    case (ckps)
      CKPS_1:  return 3'd0;
      CKPS_2:  return 3'd1;
      CKPS_4:  return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/timer1_peripheral_edge_sync_detect.sv
// Two-flop synchroniser plus rising-edge detect for an asynchronous input pin.
// Reusable for any external-pin peripheral (T1CKI, RB0/INT, capture inputs).
module edge_sync_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic p;

  // Synchronise the pin into clk and keep the previous synchronised value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      p  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make s1/s2/p a true shift chain; blocking ones would collapse it into one flop.
      s1 <= din;
      s2 <= s1;
      p  <= s2;
    end
  end

  assign rise = s2 & ~p;

endmodule

// File: rtl/timer1_peripheral.sv
// Timer1: 16-bit counter clocked from clk/4 or a synchronised T1CKI pin,
// through a 1/2/4/8 prescaler, with a one-cycle strobe on overflow.
module timer1_peripheral
  import timer1_pkg::*;
#(
  parameter logic [8:0] TMR1L_ADDR = TMR1L_ADDR_DEFAULT,
  parameter logic [8:0] TMR1H_ADDR = TMR1H_ADDR_DEFAULT,
  parameter logic [8:0] T1CON_ADDR = T1CON_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] addr,
  input  logic       rd_en,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       t1cki,
  output logic       tmr1if_strobe
);

  logic [15:0] tmr1;
  logic [5:0]  t1con;
  logic [2:0]  presc;
  logic [1:0]  phase;
  logic        strobe;

  logic wr_l;
  logic wr_h;
  logic wr_t1con;
  logic int_tick;
  logic ext_tick;
  logic src_tick;
  logic count_en;
  logic presc_wrap;

  assign wr_l     = wr_en && (addr == TMR1L_ADDR);
  assign wr_h     = wr_en && (addr == TMR1H_ADDR);
  assign wr_t1con = wr_en && (addr == T1CON_ADDR);

  edge_sync_detect u_t1cki_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (t1cki),
    .rise (ext_tick)
  );

  // Free-running phase counter producing the clk/4 instruction-clock tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase <= 2'b00;
    else     phase <= phase + 2'd1;
  end

  assign int_tick = (phase == 2'b11);
  assign src_tick = t1con[T1CON_TMR1CS] ? ext_tick : int_tick;
  assign count_en = t1con[T1CON_TMR1ON] & src_tick;

  // A count left above a newly reduced ratio runs on to 3'b111 and wraps there.
  assign presc_wrap = (presc == ckps_last(ckps_e'(t1con[T1CON_CKPS_HI:T1CON_CKPS_LO])))
                   || (presc == 3'b111);

  // Register writes, prescaler and counter; a TMR1 byte write beats an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr1   <= 16'h0000;
      t1con  <= 6'h00;
      presc  <= 3'd0;
      strobe <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (wr_t1con) t1con <= data_in[5:0];
      if (wr_l || wr_h) begin
        presc <= 3'd0;
        if (wr_l) tmr1[7:0]  <= data_in;
        if (wr_h) tmr1[15:8] <= data_in;
      end else if (count_en) begin
        if (presc_wrap) begin
          presc  <= 3'd0;
          tmr1   <= tmr1 + 16'd1;
          strobe <= (tmr1 == 16'hFFFF);
        end else begin
          presc <= presc + 3'd1;
        end
      end
    end
  end

  assign tmr1if_strobe = strobe;

  // Combinational read mux; idle value is zero so peripheral outputs can be ORed.
  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    data_out = 8'h00;
    if (rd_en) begin
      if (addr == TMR1L_ADDR)      data_out = tmr1[7:0];
      else if (addr == TMR1H_ADDR) data_out = tmr1[15:8];
      else if (addr == T1CON_ADDR) data_out = {2'b00, t1con};
    end
  end

endmodule

// File: tb/tb_timer1_peripheral.sv
// Self-checking bench for timer1_peripheral.
module tb_timer1_peripheral;
  import timer1_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] addr = '0;
  logic       rd_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       t1cki = 1'b0;
  logic       tmr1if_strobe;

  localparam logic [8:0] A_L = TMR1L_ADDR_DEFAULT;
  localparam logic [8:0] A_H = TMR1H_ADDR_DEFAULT;
  localparam logic [8:0] A_C = T1CON_ADDR_DEFAULT;

  timer1_peripheral dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .rd_en         (rd_en),
    .wr_en         (wr_en),
    .data_in       (data_in),
    .data_out      (data_out),
    .t1cki         (t1cki),
    .tmr1if_strobe (tmr1if_strobe)
  );

  always #5 clk = ~clk;

  // Model of the core's sticky PIR1.TMR1IF bit
  logic pir1_bit0;
  logic pir1_clr = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst)                pir1_bit0 <= 1'b0;
    else if (pir1_clr)      pir1_bit0 <= 1'b0;
    else if (tmr1if_strobe) pir1_bit0 <= 1'b1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic       wr;
    logic       chk;
    logic       rd;
    logic [8:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    string      name;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    logic [7:0]  t1con;
    int          clks;
    logic [15:0] exp;
    string       name;
  } rate_t;
  rate_t rates[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [15:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input logic [15:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  // Entered at a negedge; the write lands on the following posedge.
  task automatic bus_wr(input logic [8:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; addr = '0;
  endtask

  task automatic bus_rd(input logic [8:0] a, output logic [7:0] v);
    addr = a; rd_en = 1'b1;
    #1 v = data_out;
    rd_en = 1'b0; addr = '0;
  endtask

  task automatic rd16(output logic [15:0] v);
    logic [7:0] lo, hi;
    bus_rd(A_L, lo);
    bus_rd(A_H, hi);
    v = {hi, lo};
  endtask

  task automatic rd_expect(input logic [8:0] a, input logic [7:0] exp, input string name);
    logic [7:0] v;
    sb_push(name, {8'h00, exp});
    bus_rd(a, v);
    sb_compare({8'h00, v});
  endtask

  task automatic tmr_expect(input logic [15:0] exp, input string name);
    logic [15:0] v;
    sb_push(name, exp);
    rd16(v);
    sb_compare(v);
  endtask

  task automatic add_vec(input logic wr, input logic chk, input logic rd, input logic [8:0] a,
                         input logic [7:0] d, input logic [7:0] exp, input string name);
    vec_t v;
    v.wr = wr; v.chk = chk; v.rd = rd; v.a = a; v.d = d; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic add_rate(input logic [7:0] c, input int clks, input logic [15:0] exp, input string name);
    rate_t r;
    r.t1con = c; r.clks = clks; r.exp = exp; r.name = name;
    rates.push_back(r);
  endtask

  task automatic clear_pir1();
    pir1_clr = 1'b1;
    @(negedge clk);
    pir1_clr = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    logic [7:0]  b;
    int          n_str;
    logic        coincide;
    logic        found;

    // Register access vectors
    add_vec(0, 1, 1, A_L,    8'h00, 8'h00, "rst_tmr1l");
    add_vec(0, 1, 1, A_H,    8'h00, 8'h00, "rst_tmr1h");
    add_vec(0, 1, 1, A_C,    8'h00, 8'h00, "rst_t1con");
    add_vec(0, 1, 1, 9'h011, 8'h00, 8'h00, "unmapped_hi");
    add_vec(1, 1, 1, A_L,    8'hAB, 8'hAB, "wr_rd_tmr1l");
    add_vec(0, 1, 0, A_L,    8'h00, 8'h00, "no_rd_en");
    add_vec(1, 1, 1, A_H,    8'hCD, 8'hCD, "wr_rd_tmr1h");
    add_vec(1, 1, 1, A_C,    8'hFE, 8'h3E, "t1con_mask");
    add_vec(0, 1, 1, 9'h00D, 8'h00, 8'h00, "unmapped_lo");
    add_vec(1, 1, 1, A_C,    8'h00, 8'h00, "t1con_clear");

    // Internal-clock rates: {T1CON, clks run, expected TMR1}
    add_rate(8'h01, 40, 16'd10, "int_1to1");
    add_rate(8'h11, 32, 16'd4,  "int_1to2");
    add_rate(8'h21, 32, 16'd2,  "int_1to4");
    add_rate(8'h31, 64, 16'd2,  "int_1to8");

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_strobe", 16'(tmr1if_strobe), 16'd0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_wr(vecs[i].a, vecs[i].d);
      if (vecs[i].chk) begin
        sb_push(vecs[i].name, {8'h00, vecs[i].exp});
        addr = vecs[i].a; rd_en = vecs[i].rd;
        #1 b = data_out;
        rd_en = 1'b0; addr = '0;
        sb_compare({8'h00, b});
      end
    end

    // Exact count over a whole number of 4-clk phases, starting from zero
    foreach (rates[i]) begin
      bus_wr(A_C, 8'h00);
      bus_wr(A_L, 8'h00);
      bus_wr(A_H, 8'h00);
      bus_wr(A_C, rates[i].t1con);
      repeat (rates[i].clks) @(negedge clk);
      tmr_expect(rates[i].exp, rates[i].name);
    end

    // 1:8 still running at TMR1=2: write TMR1L mid-prescale clears the prescaler
    repeat (12) @(negedge clk);
    bus_wr(A_L, 8'h00);
    repeat (28) @(negedge clk);
    tmr_expect(16'h0000, "presc_clear_7ticks");
    repeat (4) @(negedge clk);
    tmr_expect(16'h0001, "presc_clear_8ticks");

    // Overflow FFFE -> FFFF -> 0000 with a single coincident strobe
    bus_wr(A_C, 8'h00);
    bus_wr(A_H, 8'hFF);
    bus_wr(A_L, 8'hFE);
    clear_pir1();
    bus_wr(A_C, 8'h01);
    n_str = 0;
    coincide = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd16(v);
      if (tmr1if_strobe) begin
        n_str++;
        if (v == 16'h0000) coincide = 1'b1;
      end
    end
    check("ovf_value", v, 16'h0000);
    check("ovf_strobe_count", 16'(n_str), 16'd1);
    check("ovf_strobe_at_zero", 16'(coincide), 16'd1);
    check("ovf_pir1_set", 16'(pir1_bit0), 16'd1);

    // External clock: increment lands between 2 and 3 clks after the rising edge
    bus_wr(A_C, 8'h00);
    bus_wr(A_L, 8'h00);
    bus_wr(A_H, 8'h00);
    bus_wr(A_C, 8'h03);
    for (int p = 0; p < 5; p++) begin
      t1cki = 1'b1;
      repeat (2) @(negedge clk);
      tmr_expect(16'(p), "ext_before_2clk");
      @(negedge clk);
      tmr_expect(16'(p + 1), "ext_by_3clk");
      @(negedge clk);
      t1cki = 1'b0;
      repeat (4) @(negedge clk);
    end
    tmr_expect(16'd5, "ext_total");

    // External edges with TMR1ON=0 are ignored
    bus_wr(A_C, 8'h02);
    for (int p = 0; p < 3; p++) begin
      t1cki = 1'b1;
      repeat (4) @(negedge clk);
      t1cki = 1'b0;
      repeat (4) @(negedge clk);
    end
    tmr_expect(16'd5, "ext_off_hold");

    // Collision: find the tick phase, then land a TMR1H write on the wrap tick
    bus_wr(A_C, 8'h00);
    bus_wr(A_L, 8'h00);
    bus_wr(A_H, 8'h00);
    clear_pir1();
    bus_wr(A_C, 8'h01);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd16(v);
      if (v != 16'h0000) begin
        found = 1'b1;
        break;
      end
    end
    check("collision_phase_found", 16'(found), 16'd1);
    bus_wr(A_L, 8'hFF);
    bus_wr(A_H, 8'hFF);
    tmr_expect(16'hFFFF, "collision_preload");
    @(negedge clk);
    bus_wr(A_H, 8'h12);
    n_str = int'(tmr1if_strobe);
    tmr_expect(16'h12FF, "collision_value");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tmr1if_strobe) n_str++;
    end
    check("collision_no_strobe", 16'(n_str), 16'd0);
    check("collision_pir1_clear", 16'(pir1_bit0), 16'd0);

    // Asynchronous reset mid-count clears everything immediately
    #2 rst = 1'b1;
    #1;
    rd_expect(A_L, 8'h00, "arst_tmr1l");
    rd_expect(A_H, 8'h00, "arst_tmr1h");
    rd_expect(A_C, 8'h00, "arst_t1con");
    check("arst_strobe", 16'(tmr1if_strobe), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    tmr_expect(16'h0000, "post_rst_stopped");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer1_peripheral.md
Name: timer1_peripheral

Overview:
- 16-bit Timer1 peripheral on the core's external-peripheral register bus.
- Memory-mapped registers: TMR1L, TMR1H, T1CON.
- Counts either the internally derived instruction clock (clk/4) or synchronised rising edges of an external T1CKI pin, through a 1/2/4/8 prescaler.
- On 16-bit overflow, emits a one-cycle interrupt strobe that feeds one bit of the core's peripheral interrupt-strobe input (PIR1.TMR1IF).

Parameters:
- TMR1L_ADDR, 9'h00E, bus address of the counter low byte.
- TMR1H_ADDR, 9'h00F, bus address of the counter high byte.
- T1CON_ADDR, 9'h010, bus address of the control register.

Ports:
- clk  input  1  system clock (same clock as the core).
- rst  input  1  asynchronous, active-high reset; driven from the core's rst_peripherals.
- addr  input  9  register-file address from the core.
- rd_en  input  1  bus read enable.
- wr_en  input  1  bus write enable.
- data_in  input  8  write data (core ALU output).
- data_out  output  8  read data; 8'h00 when not selected, so peripheral outputs can be ORed.
- t1cki  input  1  external clock pin, asynchronous to clk.
- tmr1if_strobe  output  1  one-clk pulse on overflow; wired to extern_peripherals_interrupt_strobes[0].

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-high (rst). All state clears immediately:
  - TMR1 = 16'h0000, T1CON = 8'h00.
  - Prescaler count = 0, phase counter = 0, synchroniser flops = 0.
  - tmr1if_strobe = 0. data_out follows the combinational rule below (8'h00 when idle).
- T1CON fields:
  - [7:6] read as 0, writes ignored.
  - [5:4] T1CKPS: 00=1:1, 01=1:2, 10=1:4, 11=1:8.
  - [3] T1OSCEN and [2] T1SYNC_n: stored and readable, no functional effect.
  - [1] TMR1CS: 0=internal, 1=t1cki.
  - [0] TMR1ON.
- Read path: combinational. When rd_en is high and addr matches, data_out = TMR1[7:0], TMR1[15:8] or {2'b00, T1CON[5:0]}; otherwise 8'h00. Reads have no side effects and no high-byte latching.
- Write path: on a clk edge with wr_en high and a matching addr, the selected register takes data_in.
  - A write to TMR1L or TMR1H replaces only that byte and clears the prescaler count.
  - A T1CON write does not clear the prescaler.
- Internal tick: a 2-bit phase counter is free-running from reset (it runs regardless of TMR1ON). int_tick = (phase == 2'b11), giving one pulse per 4 clks.
- External tick: t1cki passes through a two-flop synchroniser (s1 -> s2) plus a previous-value flop p. ext_tick = s2 & ~p. A rising edge on t1cki therefore yields ext_tick 2-3 clks later. The synchroniser always runs.
- Source select: src_tick = TMR1CS ? ext_tick : int_tick.
- Prescaler, when TMR1ON=1 and src_tick=1:
  - If the prescaler count equals (ratio-1), the count returns to 0 and a counter increment occurs.
  - Otherwise the prescaler count increments.
  - With ratio 1 every src_tick increments the counter.
- Counter increment: TMR1 <= TMR1 + 1, modulo 2^16.
  - When TMR1 == 16'hFFFF, it wraps to 16'h0000 and tmr1if_strobe is registered high for exactly the same cycle TMR1 reads 0, then returns to 0.
- TMR1ON=0: counter and prescaler hold their values. No strobe.
- Simultaneous bus write to TMR1L/TMR1H and increment:
  - The write wins: the written byte is loaded, the other byte holds, and no increment occurs.
  - No strobe is produced, even if the pre-write value was 16'hFFFF.
  - The prescaler clears.
- Simultaneous T1CON write and tick: the tick is evaluated with the old T1CON; the new value takes effect from the next cycle.
- Reset mid-count: everything clears asynchronously, and any pending strobe is dropped.
- Changing T1CKPS to a smaller ratio while the prescaler count ≥ the new ratio: the count increments until it wraps at 3'b111 to 0, with an increment at that wrap. This corner is documented, not fixed.

Decomposition:
- Shared package/header (alongside the existing memory map include) holds:
  - TMR1L/TMR1H/T1CON addresses.
  - T1CON bit-index constants.
  - Prescaler-ratio encoding.
- Natural sub-module: edge_sync_detect, covering the two-flop synchroniser plus rising-edge detect. It is reusable for future external-pin peripherals (RB0/INT, capture inputs).
- The top of the block holds:
  - the registers;
  - the phase counter;
  - the prescaler;
  - the bus decode.

Test Plan:
- Reset then read: assert rst, then read each of the three addresses -> data_out = 8'h00; tmr1if_strobe = 0; an unmapped address read returns 8'h00.
- Internal 1:1 count: write T1CON=8'h01 and run 40 clks -> TMR1 advances by exactly 10 (one increment per 4 clks).
- Prescaler 1:8 and write-clear:
  - T1CON=8'h31, run 64 clks -> TMR1=2.
  - Write TMR1L=8'h00 mid-prescale -> the next increment comes only after 8 further int_ticks.
- Overflow: load TMR1H=8'hFF and TMR1L=8'hFE, set T1CON=8'h01 -> after 2 ticks TMR1=16'h0000 with tmr1if_strobe high for exactly 1 clk coincident with that transition; the bench checks the core's PIR1 bit0 becomes set.
- External clock: T1CON=8'h03, apply 5 t1cki pulses (each high ≥3 clks) -> TMR1=5, with each increment 2-3 clks after the rising edge. Toggling t1cki with TMR1ON=0 -> no change.
- Write/increment collision: TMR1=16'hFFFF running 1:1, with a write TMR1H=8'h12 landing on the increment cycle -> TMR1=16'h12FF and no strobe.
